multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I datapath. Decodes the latched instruction's opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. Drives datapath mux selects, write strobes and the 2-bit `alu_op` consumed by the ALU control decoder. Stalls on a single-bit memory ready handshake.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle RV32I controller.
// The master side is the control FSM: it consumes instruction fields and
// status and drives the datapath selects and strobes. The slave side is the
// datapath (or a testbench standing in for it).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, instr_done, illegal,
           mem_timeout
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, instr_done, illegal,
           mem_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects
// and strobes, and stalls on the single-bit mem_ready handshake.
// Optional feature macro: JAL_EN -- when defined, opcode 1101111 runs through
// a JAL state; when undefined that opcode is treated as illegal (HALT).
// Outputs are decoded from the state register; a few strobes also follow
// mem_ready / zero in the cycle they apply, so they are not registered.
module multicycle_control #(
  parameter int WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

`ifdef JAL_EN
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
    EXEC_R, EXEC_I, ALUWB, BEQ, JAL, HALT
  } state_t;
`else
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
    EXEC_R, EXEC_I, ALUWB, BEQ, HALT
  } state_t;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [7:0] WAIT_LIM  = 8'(WAIT_MAX);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       waiting;
  logic       timeout_q;

  // A memory-facing state with no ready this cycle is a stall cycle.
  assign waiting  = !bus.mem_ready &&
                    (state == FETCH || state == MEMREAD || state == MEMWRITE);
  // Counter saturates so a very long stall cannot wrap back under the limit.
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign bus.mem_timeout = timeout_q;

  // State sequencing plus the stall counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      // Leaving a wait state always passes through a non-stall cycle, so
      // clearing whenever not stalled is the same as clearing on entry.
      if (waiting) begin
        wait_cnt <= wait_inc;
        if (WAIT_LIM != 8'd0 && wait_inc >= WAIT_LIM) timeout_q <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXEC_R;
            OP_ITYPE:          state <= (bus.funct3 == 3'b000) ? EXEC_I : HALT;
            OP_BRANCH:         state <= BEQ;
`ifdef JAL_EN
            OP_JAL:            state <= JAL;
`endif
            default:           state <= HALT;
          endcase
        end
        // opcode bit 5 separates store (0100011) from load (0000011).
        MEMADR:   state <= bus.opcode[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (bus.mem_ready) state <= MEMWB;
        MEMWRITE: if (bus.mem_ready) state <= FETCH;
        MEMWB:    state <= FETCH;
        EXEC_R:   state <= ALUWB;
        EXEC_I:   state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
`ifdef JAL_EN
        JAL:      state <= ALUWB;
`endif
        HALT:     state <= HALT;
        default:  state <= HALT;
      endcase
    end
  end

  // Output decode; during reset show FETCH selects with every strobe low.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (bus.opcode)
      OP_STORE:  bus.imm_src = 2'b01;
      OP_BRANCH: bus.imm_src = 2'b10;
      OP_JAL:    bus.imm_src = 2'b11;
      default:   bus.imm_src = 2'b00;
    endcase
    if (reset) begin
      bus.result_src = 2'b10;
      bus.alu_src_b  = 2'b10;
    end else begin
      case (state)
        FETCH: begin
          bus.result_src = 2'b10;
          bus.alu_src_b  = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        MEMADR, EXEC_I: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        MEMREAD:  bus.adr_src = 1'b1;
        MEMWRITE: begin
          bus.adr_src    = 1'b1;
          bus.mem_write  = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        MEMWB: begin
          bus.result_src = 2'b01;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        EXEC_R: begin
          bus.alu_src_a = 2'b10;
          bus.alu_op    = 2'b10;
        end
        ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        BEQ: begin
          bus.alu_src_a  = 2'b10;
          bus.alu_op     = 2'b01;
          bus.pc_write   = bus.zero;
          bus.instr_done = 1'b1;
        end
`ifdef JAL_EN
        JAL: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.pc_write  = 1'b1;
        end
`endif
        HALT:    bus.illegal = 1'b1;
        default: bus.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table for the
// basic instruction flows, plus hand sequences for stalls, HALT, timeout,
// reset mid-instruction and JAL.
module tb_multicycle_control;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic clk;
  logic reset;
  multicycle_control_if bus();

  multicycle_control #(.WAIT_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
  //  alu_src_b, alu_op, reg_write, instr_done, illegal}
  logic [14:0] act_v;
  assign act_v = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                  bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.reg_write, bus.instr_done, bus.illegal};

  function automatic logic [14:0] e(input int pw, as, mw, iw, rs, sa, sb,
                                    op, rw, dn, il);
    return {1'(pw), 1'(as), 1'(mw), 1'(iw), 2'(rs), 2'(sa), 2'(sb), 2'(op),
            1'(rw), 1'(dn), 1'(il)};
  endfunction

  typedef struct {
    string       nm;
    logic        rst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [14:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input int rst, input logic [6:0] opc,
                     input int f3, input int z, input int rdy,
                     input logic [14:0] ex);
    vec_t v;
    v.nm = nm; v.rst = 1'(rst); v.opc = opc; v.f3 = 3'(f3);
    v.z = 1'(z); v.rdy = 1'(rdy); v.ex = ex;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, settle before the rising edge.
  task automatic tick(input int rst, input logic [6:0] opc, input int f3,
                      input int z, input int rdy);
    @(negedge clk);
    reset         = 1'(rst);
    bus.opcode    = opc;
    bus.funct3    = 3'(f3);
    bus.zero      = 1'(z);
    bus.mem_ready = 1'(rdy);
    #2;
  endtask

  task automatic cyc(input string nm, input int rst, input logic [6:0] opc,
                     input int f3, input int z, input int rdy,
                     input logic [14:0] ex);
    tick(rst, opc, f3, z, rdy);
    chk(nm, 32'(act_v), 32'(ex));
  endtask

  logic [14:0] S_RST, S_F0, S_F1, S_DEC, S_MA, S_MR, S_MW0, S_MW1, S_MWB;
  logic [14:0] S_XR, S_XI, S_AWB, S_BQ0, S_BQ1, S_JAL, S_HALT;

  initial begin
    logic [6:0] iops [5];
    logic [1:0] iexp [5];
    int bad;

    reset = 1'b1; bus.opcode = R; bus.funct3 = 3'd0; bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    //          pw as mw iw rs sa sb op rw dn il
    S_RST  = e(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0);
    S_F0   = e(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0);
    S_F1   = e(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0);
    S_DEC  = e(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    S_MA   = e(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    S_MR   = e(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    S_MW0  = e(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    S_MW1  = e(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    S_MWB  = e(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    S_XR   = e(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
    S_XI   = e(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    S_AWB  = e(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    S_BQ0  = e(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0);
    S_BQ1  = e(1, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0);
    S_JAL  = e(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    S_HALT = e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // mem_ready=1 during reset must not advance past FETCH.
    add("rst",          1, R,  0, 0, 1, S_RST);
    add("rst_no_adv",   0, R,  0, 0, 0, S_F0);
    add("r_fetch",      0, R,  0, 0, 1, S_F1);
    add("r_decode",     0, R,  0, 0, 0, S_DEC);
    add("r_exec",       0, R,  0, 0, 1, S_XR);
    add("r_wb",         0, R,  0, 0, 0, S_AWB);
    add("i_fetch",      0, I,  0, 0, 1, S_F1);
    add("i_decode",     0, I,  0, 0, 1, S_DEC);
    add("i_exec",       0, I,  0, 0, 0, S_XI);
    add("i_wb",         0, I,  0, 0, 1, S_AWB);
    add("sw_fetch",     0, SW, 2, 0, 1, S_F1);
    add("sw_decode",    0, SW, 2, 0, 1, S_DEC);
    add("sw_memadr",    0, SW, 2, 0, 1, S_MA);
    add("sw_memwrite",  0, SW, 2, 0, 1, S_MW1);
    add("lw_fetch",     0, LW, 2, 0, 1, S_F1);
    add("lw_decode",    0, LW, 2, 0, 1, S_DEC);
    add("lw_memadr",    0, LW, 2, 0, 1, S_MA);
    add("lw_memread",   0, LW, 2, 0, 1, S_MR);
    add("lw_memwb",     0, LW, 2, 0, 1, S_MWB);
    add("beq1_fetch",   0, BR, 0, 1, 1, S_F1);
    add("beq1_decode",  0, BR, 0, 1, 1, S_DEC);
    add("beq1_taken",   0, BR, 0, 1, 1, S_BQ1);
    add("beq0_fetch",   0, BR, 0, 0, 1, S_F1);
    add("beq0_decode",  0, BR, 0, 0, 1, S_DEC);
    add("beq0_nottkn",  0, BR, 0, 0, 1, S_BQ0);
    add("bad_fetch",    0, BAD,0, 0, 1, S_F1);
    add("bad_decode",   0, BAD,0, 0, 1, S_DEC);
    add("bad_halt",     0, BAD,0, 0, 1, S_HALT);
    add("bad_halt2",    0, R,  0, 1, 1, S_HALT);
    add("halt_rst",     1, R,  0, 0, 1, S_RST);
    add("halt_exit",    0, R,  0, 0, 0, S_F0);

    foreach (tbl[k])
      cyc(tbl[k].nm, tbl[k].rst, tbl[k].opc, tbl[k].f3, tbl[k].z,
          tbl[k].rdy, tbl[k].ex);

    // imm_src is a pure function of opcode.
    iops[0] = I;  iexp[0] = 2'b00;
    iops[1] = SW; iexp[1] = 2'b01;
    iops[2] = BR; iexp[2] = 2'b10;
    iops[3] = JL; iexp[3] = 2'b11;
    iops[4] = LW; iexp[4] = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick(1, iops[k], 0, 0, 0);
      chk($sformatf("imm_src_%0d", k), 32'(bus.imm_src), 32'(iexp[k]));
    end

    // lw with 3 stall cycles in MEMREAD: 8 cycles, MEMWB last.
    tick(1, LW, 2, 0, 0);
    cyc("lww_fetch",  0, LW, 2, 0, 1, S_F1);
    cyc("lww_decode", 0, LW, 2, 0, 1, S_DEC);
    cyc("lww_memadr", 0, LW, 2, 0, 1, S_MA);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick(0, LW, 2, 0, 0);
      if (act_v !== S_MR) bad++;
    end
    chk("lww_stall_hold", 32'(bad), 32'd0);
    cyc("lww_memread_rdy", 0, LW, 2, 0, 1, S_MR);
    cyc("lww_memwb",       0, LW, 2, 0, 1, S_MWB);
    chk("lww_no_timeout", 32'(bus.mem_timeout), 32'd0);
    cyc("lww_next_fetch",  0, LW, 2, 0, 0, S_F0);

    // addi with funct3=001 is illegal; HALT holds for 20 cycles.
    tick(1, I, 1, 0, 0);
    cyc("halt_fetch",  0, I, 1, 0, 1, S_F1);
    cyc("halt_decode", 0, I, 1, 0, 1, S_DEC);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, I, 1, k % 2, 1);
      if (act_v !== S_HALT) bad++;
    end
    chk("halt_hold_20", 32'(bad), 32'd0);
    cyc("halt_reset", 1, I, 1, 0, 1, S_RST);
    cyc("halt_to_fetch", 0, R, 0, 0, 0, S_F0);

    // Timeout with WAIT_MAX=4: rises after the 4th FETCH stall, then sticks.
    tick(1, R, 0, 0, 0);
    for (int k = 0; k <= 5; k++) begin
      tick(0, R, 0, 0, 0);
      chk($sformatf("tmo_after_%0d_waits", k), 32'(bus.mem_timeout),
          (k >= 4) ? 32'd1 : 32'd0);
    end
    tick(0, R, 0, 0, 1);
    tick(0, R, 0, 0, 1);
    tick(0, R, 0, 0, 1);
    chk("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
    tick(1, R, 0, 0, 0);
    tick(0, R, 0, 0, 0);
    chk("tmo_reset_clears", 32'(bus.mem_timeout), 32'd0);

    // Reset while stalled in MEMWRITE abandons the store.
    tick(1, SW, 2, 0, 0);
    cyc("rsw_fetch",    0, SW, 2, 0, 1, S_F1);
    cyc("rsw_decode",   0, SW, 2, 0, 1, S_DEC);
    cyc("rsw_memadr",   0, SW, 2, 0, 1, S_MA);
    cyc("rsw_memwrite", 0, SW, 2, 0, 0, S_MW0);
    cyc("rsw_reset",    1, SW, 2, 0, 1, S_RST);
    cyc("rsw_fetch2",   0, SW, 2, 0, 0, S_F0);

    // jal: real sequence when enabled, otherwise illegal.
    tick(1, JL, 0, 0, 0);
    cyc("jal_fetch",  0, JL, 0, 0, 1, S_F1);
    cyc("jal_decode", 0, JL, 0, 0, 1, S_DEC);
`ifdef JAL_EN
    cyc("jal_jal",    0, JL, 0, 0, 1, S_JAL);
    cyc("jal_wb",     0, JL, 0, 0, 1, S_AWB);
    cyc("jal_fetch2", 0, JL, 0, 0, 0, S_F0);
`else
    cyc("jal_halt",   0, JL, 0, 0, 1, S_HALT);
    cyc("jal_halt2",  0, JL, 0, 0, 1, S_HALT);
    chk("jal_jal_unused", 32'(S_JAL[14]), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
